// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice stepped LSB-first across WIDTH bits.
// Optional build macro SERIAL_ADDER_SUB_EN enables A-B (A + ~B + 1) via the sub input.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_sh, b_sh, sum_sh;
    logic [CNT_W-1:0]   cnt;
    logic               cy;
    logic               sub_r;
    logic               co_r, ov_r;
    logic               sub_eff;
    logic               accept, last_bit;
    logic               b_bit, s0, c0, s1, c1, cell_s, cell_c;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    // sub is still connected so both builds share one port list; it never affects the result
    assign sub_eff = sub & 1'b0;
`endif

    assign accept   = start && (state != RUN);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Full-adder slice: two half adders plus an OR on their carries
    assign b_bit = b_sh[0] ^ sub_r;
    half_adder u_ha0 (.x(a_sh[0]), .y(b_bit), .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0),      .y(cy),    .s(s1), .c(c1));
    assign cell_s = s1;
    assign cell_c = c0 | c1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            cy     <= 1'b0;
            sub_r  <= 1'b0;
            co_r   <= 1'b0;
            ov_r   <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            cnt    <= '0;
            cy     <= sub_eff;
            sub_r  <= sub_eff;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {cell_s, sum_sh[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
            cy     <= cell_c;
            if (last_bit) begin
                // cy here is the carry into the MSB
                co_r <= cell_c;
                ov_r <= cy ^ cell_c;
            end
        end
    end

    assign ready     = (state != RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign sum       = sum_sh;
    assign carry_out = co_r;
    assign overflow  = ov_r;

endmodule
